// File: rtl/regfile_bist_ctrl.sv
// Built-in self-test initiator for the 8-entry register file: writes a pattern
// and its complement to every register, reads each back and reports the result.
`timescale 1ns/1ps

module regfile_bist_ctrl #(
  parameter int               WIDTH   = 16,
  parameter logic [WIDTH-1:0] PATTERN = WIDTH'(16'hA5A5)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  input  logic [WIDTH-1:0] data_out,
  output logic             write,
  output logic [2:0]       writenum,
  output logic [WIDTH-1:0] data_in,
  output logic [2:0]       readnum,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [4:0]       err_count,
  output logic [2:0]       first_fail_reg,
  output logic             first_fail_pass
);

  typedef enum logic [1:0] {IDLE, WR, RD, DONE} state_t;

  state_t           state, state_n;
  logic [2:0]       idx, idx_n;
  logic             p, p_n;
  logic [4:0]       err_n;
  logic [2:0]       ffr_n;
  logic             ffp_n;
  logic [WIDTH-1:0] expected;

  // Pattern for register i in pass pass_bit; the complement pass flips every bit.
  function automatic logic [WIDTH-1:0] pat(input logic pass_bit, input logic [2:0] i);
    logic [WIDTH-1:0] v;
    v = PATTERN ^ (WIDTH'(i) * WIDTH'(16'h1111));
    return pass_bit ? ~v : v;
  endfunction

  assign expected = pat(p, idx);

  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= IDLE;
      idx             <= 3'd0;
      p               <= 1'b0;
      err_count       <= 5'd0;
      first_fail_reg  <= 3'd0;
      first_fail_pass <= 1'b0;
    end else begin
      state           <= state_n;
      idx             <= idx_n;
      p               <= p_n;
      err_count       <= err_n;
      first_fail_reg  <= ffr_n;
      first_fail_pass <= ffp_n;
    end
  end

  // Register-file port signals depend only on state/idx/p, never on start, abort or data_out.
  always_comb begin
    state_n  = state;
    idx_n    = idx;
    p_n      = p;
    err_n    = err_count;
    ffr_n    = first_fail_reg;
    ffp_n    = first_fail_pass;
    write    = 1'b0;
    writenum = 3'd0;
    data_in  = '0;
    readnum  = 3'd0;

    case (state)
      IDLE, DONE: begin
        if (start && !abort) begin
          state_n = WR;
          idx_n   = 3'd0;
          p_n     = 1'b0;
          err_n   = 5'd0;
          ffr_n   = 3'd0;
          ffp_n   = 1'b0;
        end
      end

      WR: begin
        write    = 1'b1;
        writenum = idx;
        data_in  = expected;
        if (abort) begin
          state_n = IDLE;
        end else begin
          idx_n = idx + 3'd1;
          if (idx == 3'd7) state_n = RD;
        end
      end

      RD: begin
        readnum = idx;
        if (abort) begin
          state_n = IDLE;
        end else begin
          if (data_out != expected) begin
            if (err_count != 5'd16) err_n = err_count + 5'd1;
            if (err_count == 5'd0) begin
              ffr_n = idx;
              ffp_n = p;
            end
          end
          idx_n = idx + 3'd1;
          if (idx == 3'd7) begin
            if (!p) begin
              state_n = WR;
              p_n     = 1'b1;
            end else begin
              state_n = DONE;
            end
          end
        end
      end

      default: state_n = IDLE;
    endcase
  end

  assign busy = (state == WR) || (state == RD);
  assign done = (state == DONE);
  assign pass = done && (err_count == 5'd0);

endmodule

// File: tb/tb_regfile_bist_ctrl.sv
// Self-checking bench: a faultable register-file model feeds the BIST controller and
// a spec-level reference predicts the write stream and the reported results.
`timescale 1ns/1ps

module tb_regfile_bist_ctrl;

  logic        clk = 1'b0;
  logic        reset, start, abort;
  logic [15:0] data_out;
  logic        write, busy, done, pass, first_fail_pass;
  logic [2:0]  writenum, readnum, first_fail_reg;
  logic [15:0] data_in;
  logic [4:0]  err_count;

  int n_checks = 0;
  int n_pass   = 0;

  // Fault model: 0 ideal, 1 one register bit stuck, 2 writes ignored (reads return 0).
  int          fmode = 0;
  logic [2:0]  freg  = 3'd0;
  int          fbit  = 0;
  logic        fval  = 1'b0;
  logic [15:0] rf [8];
  logic [18:0] wq [$];

  regfile_bist_ctrl #(.WIDTH(16), .PATTERN(16'hA5A5)) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort), .data_out(data_out),
    .write(write), .writenum(writenum), .data_in(data_in), .readnum(readnum),
    .busy(busy), .done(done), .pass(pass), .err_count(err_count),
    .first_fail_reg(first_fail_reg), .first_fail_pass(first_fail_pass)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (write) begin
      rf[writenum] <= data_in;
      wq.push_back({writenum, data_in});
    end
  end

  always_comb begin
    data_out = rf[readnum];
    if (fmode == 1 && readnum == freg) data_out[fbit] = fval;
    if (fmode == 2) data_out = 16'h0000;
  end

  function automatic logic [15:0] pat_ref(input int pp, input int i);
    logic [15:0] v;
    v = 16'hA5A5 ^ 16'(i * 'h1111);
    return (pp == 1) ? ~v : v;
  endfunction

  // Walks both passes in time order and predicts what the controller should report.
  task automatic refModel(output int err, output int ffr, output int ffp);
    logic [15:0] rd;
    err = 0; ffr = 0; ffp = 0;
    for (int pp = 0; pp < 2; pp++) begin
      for (int i = 0; i < 8; i++) begin
        rd = pat_ref(pp, i);
        if (fmode == 1 && i == int'(freg)) rd[fbit] = fval;
        if (fmode == 2) rd = 16'h0000;
        if (rd != pat_ref(pp, i)) begin
          if (err == 0) begin ffr = i; ffp = pp; end
          if (err < 16) err++;
        end
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // One start pulse: the edge consumed here is E0.
  task automatic applyStimulus();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic setFault(input int mode, input logic [2:0] r, input int b, input logic v);
    fmode = mode; freg = r; fbit = b; fval = v;
  endtask

  task automatic runTest(input string name);
    int err, ffr, ffp;
    wq.delete();
    applyStimulus();
    checkOutput({name, ".busy_e0"}, 32'(busy), 32'd1);
    checkOutput({name, ".done_e0"}, 32'(done), 32'd0);
    repeat (31) tick();
    checkOutput({name, ".done_e31"}, 32'(done), 32'd0);
    tick();
    refModel(err, ffr, ffp);
    checkOutput({name, ".done_e32"}, 32'(done), 32'd1);
    checkOutput({name, ".busy_e32"}, 32'(busy), 32'd0);
    checkOutput({name, ".write_done"}, 32'(write), 32'd0);
    checkOutput({name, ".err_count"}, 32'(err_count), 32'(err));
    checkOutput({name, ".pass"}, 32'(pass), (err == 0) ? 32'd1 : 32'd0);
    if (err != 0) begin
      checkOutput({name, ".first_fail_reg"}, 32'(first_fail_reg), 32'(ffr));
      checkOutput({name, ".first_fail_pass"}, 32'(first_fail_pass), 32'(ffp));
    end
    checkOutput({name, ".n_writes"}, 32'(wq.size()), 32'd16);
    for (int k = 0; k < 16 && k < wq.size(); k++)
      checkOutput({name, ".wr_seq"}, 32'(wq[k]), 32'({3'(k % 8), pat_ref(k / 8, k % 8)}));
  endtask

  initial begin
    int mode;
    reset = 1'b1; start = 1'b0; abort = 1'b0;
    for (int i = 0; i < 8; i++) rf[i] = 16'h0000;
    tick(); tick();
    reset = 1'b0;
    checkOutput("rst.write", 32'(write), 32'd0);
    checkOutput("rst.writenum", 32'(writenum), 32'd0);
    checkOutput("rst.data_in", 32'(data_in), 32'd0);
    checkOutput("rst.readnum", 32'(readnum), 32'd0);
    checkOutput("rst.busy", 32'(busy), 32'd0);
    checkOutput("rst.done", 32'(done), 32'd0);
    checkOutput("rst.pass", 32'(pass), 32'd0);
    checkOutput("rst.err_count", 32'(err_count), 32'd0);
    checkOutput("rst.ffr", 32'(first_fail_reg), 32'd0);
    checkOutput("rst.ffp", 32'(first_fail_pass), 32'd0);

    $display("[TB] ideal register file");
    setFault(0, 3'd0, 0, 1'b0);
    runTest("ideal");
    checkOutput("ideal.r5_p0", 32'(wq[5]), 32'({3'd5, 16'hF0F0}));
    checkOutput("ideal.r5_p1", 32'(wq[13]), 32'({3'd5, 16'h0F0F}));

    $display("[TB] R3 bit0 stuck at 0");
    setFault(1, 3'd3, 0, 1'b0);
    runTest("stuck");
    checkOutput("stuck.err_const", 32'(err_count), 32'd1);
    checkOutput("stuck.ffr_const", 32'(first_fail_reg), 32'd3);
    checkOutput("stuck.ffp_const", 32'(first_fail_pass), 32'd1);

    $display("[TB] back-to-back run refreshes results");
    setFault(0, 3'd0, 0, 1'b0);
    runTest("b2b");

    $display("[TB] abort and start while already done");
    abort = 1'b1; start = 1'b1;
    tick();
    abort = 1'b0; start = 1'b0;
    checkOutput("done_abort.done", 32'(done), 32'd1);
    checkOutput("done_abort.busy", 32'(busy), 32'd0);

    $display("[TB] writes ignored");
    setFault(2, 3'd0, 0, 1'b0);
    runTest("nowrite");
    checkOutput("nowrite.err_const", 32'(err_count), 32'd16);

    $display("[TB] reset mid-run at E12");
    applyStimulus();
    repeat (11) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checkOutput("midrst.write", 32'(write), 32'd0);
    checkOutput("midrst.busy", 32'(busy), 32'd0);
    checkOutput("midrst.done", 32'(done), 32'd0);
    checkOutput("midrst.err_count", 32'(err_count), 32'd0);
    setFault(0, 3'd0, 0, 1'b0);
    runTest("after_rst");

    $display("[TB] ignored start at E5, abort at E20");
    applyStimulus();
    repeat (4) tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    checkOutput("e5.writenum", 32'(writenum), 32'd5);
    checkOutput("e5.write", 32'(write), 32'd1);
    repeat (14) tick();
    abort = 1'b1; start = 1'b1;
    tick();
    abort = 1'b0; start = 1'b0;
    checkOutput("abort.busy", 32'(busy), 32'd0);
    checkOutput("abort.done", 32'(done), 32'd0);
    checkOutput("abort.write", 32'(write), 32'd0);
    tick();
    checkOutput("abort.idle_busy", 32'(busy), 32'd0);
    abort = 1'b1; start = 1'b1;
    tick();
    abort = 1'b0; start = 1'b0;
    checkOutput("idle_abort.busy", 32'(busy), 32'd0);
    runTest("after_abort");

    $display("[TB] randomized fault runs");
    for (int n = 0; n < 8; n++) begin
      mode = int'($urandom_range(0, 2));
      setFault(mode, 3'($urandom_range(0, 7)), int'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
      runTest("random");
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
